// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint buffer reader.
//   FifoDepth  - entries in the read-data FIFO
//   FifoLvlW   - width of the FIFO level count (0..FifoDepth)
//   rd_state_e - reader FSM encoding
//   ptr_inc    - modulo-FifoDepth pointer increment
package usb_pkg;

  localparam int unsigned FifoDepth = 3;
  localparam int unsigned FifoLvlW  = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StFlush = 2'd2
  } rd_state_e;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FifoDepth - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/usb_ep_buf_reader_fifo.sv
// Small FIFO holding returned buffer bytes tagged with a last flag.
//   clk, rst  - clock, asynchronous active-high reset
//   flush_i   - drop all contents (wins over a same-cycle write)
//   wr_en_i   - push wr_data_i ({last, data})
//   rd_en_i   - pop the head entry
//   rd_data_o - head entry
//   level_o   - number of valid entries
//   empty_o   - no valid entries
module usb_ep_buf_reader_fifo
  import usb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                wr_en_i,
  input  logic [8:0]          wr_data_i,
  input  logic                rd_en_i,
  output logic [8:0]          rd_data_o,
  output logic [FifoLvlW-1:0] level_o,
  output logic                empty_o
);

  logic [8:0]          mem_q [FifoDepth];
  logic [8:0]          mem_d [FifoDepth];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [FifoLvlW-1:0] level_q, level_d;
  logic                do_wr, do_rd;

  assign do_wr = wr_en_i && (level_q != FifoLvlW'(FifoDepth));
  assign do_rd = rd_en_i && (level_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_rd) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_wr, do_rd})
        2'b10:   level_d = level_q + FifoLvlW'(1);
        2'b01:   level_d = level_q - FifoLvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign empty_o   = (level_q == '0);

endmodule

// File: rtl/usb_ep_buf_reader.sv
// Reads a byte range out of the endpoint buffer and streams it to the transmitter.
//   clk, rst                      - clock, asynchronous active-high reset
//   start/start_addr/start_len    - begin a transfer (ignored while busy or with abort)
//   abort                         - cancel the transfer in progress, no done pulse
//   busy, done                    - transfer active / one-cycle normal completion pulse
//   buf_rd_addr_0, buf_rd_en_0    - buffer read request
//   buf_rd_data_1                 - buffer data, one cycle after the request
//   out_data/out_valid/out_last/out_ready - byte stream with handshake
module usb_ep_buf_reader
  import usb_pkg::*;
#(
  parameter int unsigned AWIDTH = 11,
  parameter int unsigned LWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [LWIDTH-1:0] start_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] buf_rd_addr_0,
  output logic              buf_rd_en_0,
  input  logic [7:0]        buf_rd_data_1,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  rd_state_e           state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [LWIDTH-1:0]   remain_q, remain_d;
  logic                inflight_q, inflight_d;
  logic                infl_last_q, infl_last_d;
  logic                done_q, done_d;

  logic                fifo_wr, fifo_rd, fifo_empty;
  logic [8:0]          fifo_rdata;
  logic [FifoLvlW-1:0] fifo_level;
  logic                rd_room;

  // Counting in-flight reads against FIFO space keeps the FIFO from overflowing
  // even when the stream stalls.
  assign rd_room     = ((3'(fifo_level) + 3'(inflight_q)) <= 3'd2);
  assign buf_rd_en_0 = (state_q == StFetch) && (remain_q != '0) && rd_room;
  assign buf_rd_addr_0 = addr_q;

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_rdata[7:0] : 8'h00;
  assign out_last  = out_valid && fifo_rdata[8];
  assign fifo_rd   = out_valid && out_ready;
  // Data for a read issued before an abort is dropped on arrival.
  assign fifo_wr   = inflight_q && !abort;

  assign busy = (state_q != StIdle);
  assign done = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    inflight_d  = buf_rd_en_0 && !abort;
    infl_last_d = buf_rd_en_0 && (remain_q == LWIDTH'(1));
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = StFetch;
              addr_d   = start_addr;
              remain_d = start_len;
            end
          end
        end
        StFetch: begin
          if (buf_rd_en_0) begin
            addr_d   = addr_q + AWIDTH'(1);
            remain_d = remain_q - LWIDTH'(1);
            if (remain_q == LWIDTH'(1)) state_d = StFlush;
          end
        end
        StFlush: begin
          if (fifo_rd && out_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  usb_ep_buf_reader_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (abort),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({infl_last_q, buf_rd_data_1}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .level_o   (fifo_level),
    .empty_o   (fifo_empty)
  );

endmodule
